// File: rtl/async_write_ctrl.sv
// Write-side controller for the async FIFO. It owns the binary and Gray write
// pointers and synchronises the read Gray pointer into wr_clk. From those it
// produces the RAM write enable, the registered full/almost_full flags, the
// fill level and a sticky overflow error.
module async_write_ctrl #(
  parameter int ADDR_WIDTH         = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  wr_clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr_async,
  input  logic                  clr_overflow,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   gray_write_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH;

  logic [AW:0] bin;
  logic [AW:0] bin_next;
  logic [AW:0] gray_next;
  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] rq;
  logic [AW:0] rd_bin;
  logic [AW:0] level_next;
  logic        full_next;
  logic        almost_full_next;
  logic        accept;

  // reset_n gates the accept so that a write request is ignored while reset is held
  assign accept     = write_en & ~full & reset_n;
  assign mem_we     = accept;
  assign write_addr = bin[AW-1:0];
  assign rq         = sync_q[SYNC_STAGES-1];

  // Read-pointer synchroniser chain
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_gray_ptr_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray-to-binary conversion of the synchronised read pointer
  always_comb begin
    rd_bin = '0;
    for (int unsigned i = 0; i <= AW; i++) rd_bin[i] = ^(rq >> i);
  end

  // Next pointer and flag values
  always_comb begin
    bin_next         = bin + {{AW{1'b0}}, accept};
    gray_next        = bin_next ^ (bin_next >> 1);
    full_next        = (gray_next == {~rq[AW:AW-1], rq[AW-2:0]});
    level_next       = bin_next - rd_bin;
    almost_full_next = (level_next >= (AW+1)'(ALMOST_FULL_THRESH));
  end

  // Pointer and flag registers
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      bin            <= '0;
      gray_write_ptr <= '0;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      wr_level       <= '0;
    end else begin
      bin            <= bin_next;
      gray_write_ptr <= gray_next;
      full           <= full_next;
      almost_full    <= almost_full_next;
      wr_level       <= level_next;
    end
  end

  // Sticky overflow: set has priority over clear
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n)                overflow <= 1'b0;
    else if (write_en && full)   overflow <= 1'b1;
    else if (clr_overflow)       overflow <= 1'b0;
  end

  // DEPTH is kept as a named constant for the level range 0..DEPTH
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_async_write_ctrl.sv
// Directed bench for async_write_ctrl. Stimulus pushes the expected write
// addresses into a queue, and a negedge monitor pops that queue on every
// mem_we pulse. The monitor also compares gray_write_ptr each cycle against
// the bench's own pointer model.
module tb_async_write_ctrl;

  logic       wr_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_en = 1'b0;
  logic [4:0] rd_gray_ptr_async = '0;
  logic       clr_overflow = 1'b0;
  logic       mem_we;
  logic [3:0] write_addr;
  logic [4:0] gray_write_ptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_bin = '0;
  logic [3:0] addr_q [$];

  async_write_ctrl #(
    .ADDR_WIDTH(4),
    .SYNC_STAGES(2),
    .ALMOST_FULL_THRESH(12)
  ) dut (
    .wr_clk(wr_clk),
    .reset_n(reset_n),
    .write_en(write_en),
    .rd_gray_ptr_async(rd_gray_ptr_async),
    .clr_overflow(clr_overflow),
    .mem_we(mem_we),
    .write_addr(write_addr),
    .gray_write_ptr(gray_write_ptr),
    .full(full),
    .almost_full(almost_full),
    .wr_level(wr_level),
    .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle and leaves at the next posedge+1
  task automatic cyc(input logic we, input logic acc);
    write_en = we;
    if (acc) addr_q.push_back(exp_bin[3:0]);
    @(posedge wr_clk);
    #1;
    if (acc) exp_bin = exp_bin + 5'd1;
  endtask

  // Monitor: pointer model check every cycle, address scoreboard on mem_we
  initial begin
    logic [3:0] a;
    forever begin
      @(negedge wr_clk);
      chk("gray_ptr", {27'd0, gray_write_ptr}, {27'd0, g(exp_bin)});
      if (mem_we === 1'b1) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: addr %0d with nothing expected at %0t", write_addr, $time);
        end else begin
          a = addr_q.pop_front();
          chk("write_addr", {28'd0, write_addr}, {28'd0, a});
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_af", {31'd0, almost_full}, 0);
    chk("rst_level", {27'd0, wr_level}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_gray", {27'd0, gray_write_ptr}, 0);
    @(posedge wr_clk);
    #1;
    reset_n = 1'b1;

    // Fill with the read pointer held at 0
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i < 16);
      chk("fill_af", {31'd0, almost_full}, (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", {31'd0, full}, (i + 1 >= 16) ? 1 : 0);
      chk("fill_level", {27'd0, wr_level}, (i + 1 >= 16) ? 16 : i + 1);
      chk("fill_ovf", {31'd0, overflow}, (i >= 16) ? 1 : 0);
    end
    cyc(1'b0, 1'b0);

    // Overflow set beats clear, then clear alone
    clr_overflow = 1'b1;
    cyc(1'b1, 1'b0);
    chk("ovf_set_wins", {31'd0, overflow}, 1);
    cyc(1'b0, 1'b0);
    chk("ovf_cleared", {31'd0, overflow}, 0);
    clr_overflow = 1'b0;

    // Drain release: one read step is visible three edges later
    rd_gray_ptr_async = 5'b00001;
    cyc(1'b0, 1'b0);
    chk("drain_e1_full", {31'd0, full}, 1);
    cyc(1'b0, 1'b0);
    chk("drain_e2_full", {31'd0, full}, 1);
    chk("drain_e2_level", {27'd0, wr_level}, 16);
    cyc(1'b0, 1'b0);
    chk("drain_e3_full", {31'd0, full}, 0);
    chk("drain_e3_level", {27'd0, wr_level}, 15);
    chk("drain_e3_af", {31'd0, almost_full}, 1);

    // Gray integrity: empty the FIFO, then 40 writes with the reader tracking
    rd_gray_ptr_async = 5'b11000;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("empty_level", {27'd0, wr_level}, 0);
    chk("empty_af", {31'd0, almost_full}, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1);
      rd_gray_ptr_async = g(exp_bin);
    end
    chk("track_full", {31'd0, full}, 0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("track_level", {27'd0, wr_level}, 0);

    // Reset in the middle of a burst at level 7
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1);
    chk("burst_level", {27'd0, wr_level}, 7);
    write_en = 1'b1;
    #2;
    reset_n = 1'b0;
    exp_bin = '0;
    rd_gray_ptr_async = '0;
    #1;
    chk("mid_rst_we", {31'd0, mem_we}, 0);
    chk("mid_rst_addr", {28'd0, write_addr}, 0);
    chk("mid_rst_gray", {27'd0, gray_write_ptr}, 0);
    chk("mid_rst_level", {27'd0, wr_level}, 0);
    chk("mid_rst_full", {31'd0, full}, 0);
    chk("mid_rst_af", {31'd0, almost_full}, 0);
    chk("mid_rst_ovf", {31'd0, overflow}, 0);
    @(posedge wr_clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    write_en = 1'b0;
    chk("post_rst_level", {27'd0, wr_level}, 2);
    cyc(1'b0, 1'b0);

    chk("queue_drained", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
